// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: prioritised next-pc selection with a
// small circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int unsigned          WORDSIZE     = 32,
  parameter int unsigned          INSN_BYTES   = 4,
  parameter logic [WORDSIZE-1:0]  RESET_VECTOR = '0,
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                trap_valid_i,
  input  logic [WORDSIZE-1:0] trap_vector_i,
  input  logic                br_taken_i,
  input  logic [WORDSIZE-1:0] br_base_i,
  input  logic [WORDSIZE-1:0] br_offset_i,
  input  logic                ret_i,
  input  logic [WORDSIZE-1:0] ret_target_i,
  input  logic                jump_valid_i,
  input  logic [WORDSIZE-1:0] jump_target_i,
  input  logic                call_i,
  output logic [WORDSIZE-1:0] pc_o,
  output logic [WORDSIZE-1:0] pc_seq_o,
  output logic                fetch_valid_o,
  output logic                ras_empty_o,
  output logic                ras_full_o
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [2:0] {
    SrcSeq,
    SrcHold,
    SrcJump,
    SrcRet,
    SrcBranch,
    SrcTrap
  } src_e;

  logic [WORDSIZE-1:0] pc_q, pc_d;
  logic [WORDSIZE-1:0] pc_seq;
  logic [WORDSIZE-1:0] br_target;
  logic                fv_q;
  logic [PtrW-1:0]     top_q, top_d, top_inc, top_dec;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WORDSIZE-1:0] ras_q [RAS_DEPTH];
  logic                ras_empty, ras_full;
  logic                push_en;
  src_e                src;

  assign pc_seq    = pc_q + WORDSIZE'(INSN_BYTES);
  assign br_target = br_base_i + br_offset_i;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CntW'(RAS_DEPTH));
  assign top_inc   = top_q + PtrW'(1);
  assign top_dec   = top_q - PtrW'(1);

  // Fixed-priority source selection; stall only matters when nothing redirects.
  always_comb begin
    src = SrcSeq;
    if (trap_valid_i) begin
      src = SrcTrap;
    end else if (br_taken_i) begin
      src = SrcBranch;
    end else if (ret_i) begin
      src = SrcRet;
    end else if (jump_valid_i) begin
      src = SrcJump;
    end else if (stall_i) begin
      src = SrcHold;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    push_en = 1'b0;
    // The first edge after reset only raises fetch_valid; pc stays at the vector.
    if (fv_q) begin
      unique case (src)
        SrcTrap: begin
          pc_d  = trap_vector_i;
          top_d = '0;
          cnt_d = '0;
        end
        SrcBranch: begin
          pc_d = br_target;
        end
        SrcRet: begin
          if (ras_empty) begin
            pc_d = ret_target_i;
          end else begin
            pc_d  = ras_q[top_q];
            top_d = top_dec;
            cnt_d = cnt_q - CntW'(1);
          end
        end
        SrcJump: begin
          pc_d = jump_target_i;
          if (call_i) begin
            // When full, top+1 is the oldest entry, so the push overwrites it.
            push_en = 1'b1;
            top_d   = top_inc;
            if (!ras_full) begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        SrcHold: begin
          pc_d = pc_q;
        end
        default: begin
          pc_d = pc_seq;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= RESET_VECTOR;
      fv_q  <= 1'b0;
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      fv_q  <= 1'b1;
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      ras_q[top_inc] <= pc_seq;
    end
  end

  assign pc_o          = pc_q;
  assign pc_seq_o      = pc_seq;
  assign fetch_valid_o = fv_q;
  assign ras_empty_o   = ras_empty;
  assign ras_full_o    = ras_full;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_pc_unit;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, trap_valid, br_taken, ret, jump_valid, call;
  logic [31:0] trap_vector, br_base, br_offset, ret_target, jump_target;
  logic [31:0] pc, pc_seq;
  logic        fetch_valid, ras_empty, ras_full;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pc, fetch-valid flag and the RAS as a bounded queue (back = top).
  logic [31:0] m_pc = 32'h0;
  bit          m_fv = 1'b0;
  logic [31:0] m_ras[$];

  pc_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .trap_valid_i (trap_valid),
    .trap_vector_i(trap_vector),
    .br_taken_i   (br_taken),
    .br_base_i    (br_base),
    .br_offset_i  (br_offset),
    .ret_i        (ret),
    .ret_target_i (ret_target),
    .jump_valid_i (jump_valid),
    .jump_target_i(jump_target),
    .call_i       (call),
    .pc_o         (pc),
    .pc_seq_o     (pc_seq),
    .fetch_valid_o(fetch_valid),
    .ras_empty_o  (ras_empty),
    .ras_full_o   (ras_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0;
      m_fv = 1'b0;
      m_ras.delete();
    end else if (!m_fv) begin
      m_fv = 1'b1;
    end else if (trap_valid) begin
      m_pc = trap_vector;
      m_ras.delete();
    end else if (br_taken) begin
      m_pc = br_base + br_offset;
    end else if (ret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else m_pc = ret_target;
    end else if (jump_valid) begin
      if (call) begin
        if (m_ras.size() == Depth) void'(m_ras.pop_front());
        m_ras.push_back(m_pc + 32'd4);
      end
      m_pc = jump_target;
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
    end
  end

  // Outputs depend only on registered state, so the falling edge is a safe sample point.
  always @(negedge clk) begin
    chk("model.pc", pc, m_pc);
    chk("model.pc_seq", pc_seq, m_pc + 32'd4);
    chk("model.fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
    chk("model.ras_empty", {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
    chk("model.ras_full", {31'b0, ras_full}, {31'b0, m_ras.size() == Depth});
  end

  task automatic idle();
    stall = 0; trap_valid = 0; br_taken = 0; ret = 0; jump_valid = 0; call = 0;
    trap_vector = 0; br_base = 0; br_offset = 0; ret_target = 0; jump_target = 0;
  endtask

  // Apply the current inputs across one rising edge; returns at the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_jump(input logic [31:0] tgt, input logic is_call);
    idle(); jump_valid = 1; jump_target = tgt; call = is_call; step();
  endtask

  task automatic do_ret(input logic [31:0] fallback);
    idle(); ret = 1; ret_target = fallback; step();
  endtask

  initial begin
    idle();
    step(); step();
    chk("reset.pc", pc, 32'h0);
    chk("reset.fetch_valid", {31'b0, fetch_valid}, 32'h0);
    chk("reset.ras_empty", {31'b0, ras_empty}, 32'h1);

    rst = 0;
    step();
    chk("release.fetch_valid", {31'b0, fetch_valid}, 32'h1);
    chk("release.pc", pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq.pc", pc, 32'(4 * i));
    end

    // Asynchronous reset mid-cycle, while a redirect and stall are being driven.
    jump_valid = 1; jump_target = 32'h500; stall = 1;
    #2 rst = 1;
    #1;
    chk("async_reset.pc", pc, 32'h0);
    chk("async_reset.fetch_valid", {31'b0, fetch_valid}, 32'h0);
    step();
    idle();
    rst = 0;
    step();
    chk("rerelease.pc", pc, 32'h0);

    do_jump(32'hFFFF_FFFC, 1'b0);
    chk("wrap.pc_seq", pc_seq, 32'h0);
    idle(); step();
    chk("wrap.pc", pc, 32'h0);

    idle(); trap_valid = 1; trap_vector = 32'h100; br_taken = 1; br_base = 32'h700;
    jump_valid = 1; jump_target = 32'h900; step();
    chk("prio.trap", pc, 32'h100);
    idle(); br_taken = 1; br_base = 32'h2000; br_offset = 32'hFFFF_FFF0; step();
    chk("prio.branch_neg", pc, 32'h1FF0);

    do_jump(32'h40, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; step();
      chk("stall.hold", pc, 32'h40);
    end
    idle(); stall = 1; jump_valid = 1; jump_target = 32'h80; step();
    chk("stall.redirect", pc, 32'h80);

    // RAS overflow: five calls from 0x10..0x50, the oldest (0x14) is lost.
    idle(); trap_valid = 1; trap_vector = 32'h0; step();
    for (int i = 1; i <= 5; i++) begin
      do_jump(32'(16 * i), 1'b0);
      do_jump(32'h1000, 1'b1);
      if (i == 4) chk("overflow.full_after4", {31'b0, ras_full}, 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      do_ret(32'h900);
      chk("overflow.ret", pc, 32'h54 - 32'(16 * i));
    end
    chk("overflow.empty", {31'b0, ras_empty}, 32'h1);
    do_ret(32'h900);
    chk("overflow.fallback", pc, 32'h900);

    do_jump(32'h1000, 1'b1);
    do_jump(32'h2000, 1'b1);
    idle(); trap_valid = 1; trap_vector = 32'h200; step();
    chk("trapclr.empty", {31'b0, ras_empty}, 32'h1);
    do_ret(32'h300);
    chk("trapclr.ret", pc, 32'h300);

    idle(); br_taken = 1; br_base = 32'h3000; br_offset = 32'h10;
    jump_valid = 1; call = 1; jump_target = 32'h4000; step();
    chk("mask.call_pc", pc, 32'h3010);
    chk("mask.call_empty", {31'b0, ras_empty}, 32'h1);
    do_jump(32'h5000, 1'b1);
    idle(); ret = 1; ret_target = 32'h600; trap_valid = 1; trap_vector = 32'h700; step();
    chk("mask.ret_pc", pc, 32'h700);
    chk("mask.ret_empty", {31'b0, ras_empty}, 32'h1);

    for (int i = 0; i < 3000; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      trap_valid  = ($urandom_range(0, 19) == 0);
      br_taken    = ($urandom_range(0, 7) == 0);
      ret         = ($urandom_range(0, 3) == 0);
      jump_valid  = ($urandom_range(0, 2) == 0);
      call        = ($urandom_range(0, 1) == 0);
      trap_vector = $urandom & 32'hFFFF_FFFC;
      br_base     = $urandom;
      br_offset   = ($urandom_range(0, 1) == 0) ? $urandom : 32'hFFFF_FFFC;
      ret_target  = $urandom;
      jump_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1;
        step();
        rst = 0;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage. It holds the current fetch address and computes the sequential increment. Each cycle it selects the next address by fixed priority from trap, branch, return and jump redirects. A small circular return-address stack (RAS) serves call/return redirection, with stall support.

## Interface
- WORDSIZE, 32, address/data width in bits.
- INSN_BYTES, 4, sequential increment in bytes; must be less than 2^WORDSIZE.
- RESET_VECTOR, 0, value of pc while reset is asserted and immediately after it deasserts.
- RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold pc when no redirect is selected.
- trap_valid  in  1  redirect to trap_vector.
- trap_vector  in  WORDSIZE  trap handler address.
- br_taken  in  1  conditional branch resolved taken.
- br_base  in  WORDSIZE  branch base address.
- br_offset  in  WORDSIZE  branch offset, two's complement.
- ret  in  1  current instruction is a return.
- ret_target  in  WORDSIZE  fallback return address, used when the RAS is empty.
- jump_valid  in  1  unconditional jump.
- jump_target  in  WORDSIZE  jump destination.
- call  in  1  qualifies jump_valid as a call; ignored without jump_valid.
- pc  out  WORDSIZE  current fetch address (registered).
- pc_seq  out  WORDSIZE  pc + INSN_BYTES (combinational).
- fetch_valid  out  1  pc is a valid fetch address (registered).
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.

## Operation
- Next-pc priority, highest first:
  - trap_valid -> trap_vector.
  - br_taken -> br_base + br_offset.
  - ret -> RAS top, or ret_target when the RAS is empty.
  - jump_valid -> jump_target.
  - stall -> pc (hold).
  - otherwise -> pc_seq.
- A redirect is always taken, even when stall=1. stall holds pc only when no redirect is selected.
- All additions are modulo 2^WORDSIZE. Carry is discarded and no overflow is flagged. pc_seq wraps from 2^WORDSIZE - INSN_BYTES to 0.
- RAS state: storage array, top pointer (log2 RAS_DEPTH bits) and count (0..RAS_DEPTH).
- Push: occurs when jump_valid && call is the selected source. It writes pc_seq at top+1 (wrapping), advances top, and increments count, saturating at RAS_DEPTH. When the RAS is full, the push overwrites the oldest entry; count stays at RAS_DEPTH.
- Pop: occurs when ret is the selected source and count > 0. It outputs the top entry, decrements top (wrapping) and decrements count. When the RAS is empty, ret uses ret_target and RAS state is unchanged.
- trap_valid clears the RAS: count becomes 0, top becomes 0. Storage contents are don't-care.
- call or ret masked by a higher-priority source has no RAS effect.
- fetch_valid goes 0 on reset and becomes 1 on the first CLK edge with reset low. After that it stays 1 and does not depend on stall.

## Timing
- Asserting reset immediately forces, without waiting for a clock: pc=RESET_VECTOR, fetch_valid=0, RAS count=0, top=0. It does so even in the middle of a redirect or stall.
- Reset deasserting between edges: the first following edge leaves pc at RESET_VECTOR and sets fetch_valid=1. The second edge applies normal next-pc selection.
- All redirect inputs are sampled at edge N; pc holds the selected address after edge N. Redirect latency is 1 cycle, with no bubble inserted by this block.
- pc_seq, ras_empty and ras_full follow pc and RAS state combinationally, with zero latency.
- Simultaneous push and trap in the same cycle: trap wins and the RAS is cleared with no push.
- ras_full and ras_empty are never both 1.

## Test plan
- Reset and sequential run, default params: assert reset mid-run -> pc=0 and fetch_valid=0 at once. Release reset -> fetch_valid=1 at edge 1, then pc=0,4,8,12 on the next edges. pc starting at 0xFFFFFFFC -> next pc=0x00000000.
- Priority: trap_valid, br_taken and jump_valid together, trap_vector=0x100 -> pc=0x100. br_taken=1 with base=0x2000, offset=0xFFFFFFF0 -> pc=0x1FF0.
- Stall: stall=1 for 3 cycles at pc=0x40 -> pc stays 0x40. stall=1 with jump_valid=1, target=0x80 -> pc=0x80 after one edge.
- RAS overflow: 5 calls from pc 0x10,0x20,0x30,0x40,0x50 -> ras_full=1 after the 4th call. Then 4 rets -> pc=0x54,0x44,0x34,0x24, then ras_empty=1. A 5th ret with ret_target=0x900 -> pc=0x900.
- Trap clears RAS: 2 calls, then trap_valid -> ras_empty=1. A following ret uses ret_target.
- Masked call/ret: call with jump_valid and br_taken together -> branch target taken and RAS count unchanged. ret together with trap_valid -> no pop, RAS cleared.
